// File: rtl/div_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  // Operand/result width; must match the iterative divider core.
  localparam int DATA_W = 32;

  // Quotient reported for a zero divisor.
  localparam logic [DATA_W-1:0] DIV0_QUOTIENT = '1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of two operands.
// Latency: combinational.
// Backpressure: none.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg_a,
  input  logic [W-1:0] b,
  input  logic         neg_b,
  output logic [W-1:0] a_fix,
  output logic [W-1:0] b_fix
);

  // W-bit negation wraps, so the most negative value maps onto itself.
  assign a_fix = neg_a ? -a : a;
  assign b_fix = neg_b ? -b : b;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage DIV/DIVU sequencer around an unsigned iterative divider core.
// Latency: result registered one cycle after core_done (one cycle after issue on a cache hit).
// Backpressure: stall held from issue through core_done; dropped at once on flush.
// Optional: DIV_RESULT_CACHE_EN keeps the last completed op and answers repeats without the core.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W = div_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div0,
  output logic              core_en,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic [DATA_W-1:0] core_q,
  input  logic [DATA_W-1:0] core_r,
  input  logic              core_div0,
  input  logic              core_done
);

  div_state_t state;

  // Operand signs of the op in flight.
  logic sa;
  logic sb;

  // New op accepted this cycle (only meaningful in IDLE).
  logic issue;
  logic in_sa;
  logic in_sb;
  logic [DATA_W-1:0] in_a_mag;
  logic [DATA_W-1:0] in_b_mag;

  // Sign-corrected core results.
  logic [DATA_W-1:0] rem_src;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  // Cache lookup result; constant miss when the cache is not built.
  logic              cache_hit;
  logic [DATA_W-1:0] cache_hi;
  logic [DATA_W-1:0] cache_lo;
  logic              cache_div0;

  assign issue = op_valid & ~flush;
  assign in_sa = op_signed & op_a[DATA_W-1];
  assign in_sb = op_signed & op_b[DATA_W-1];

  // Magnitudes handed to the unsigned core.
  div_sign_fix #(.W(DATA_W)) u_pre_fix (
    .a     (op_a),
    .neg_a (in_sa),
    .b     (op_b),
    .neg_b (in_sb),
    .a_fix (in_a_mag),
    .b_fix (in_b_mag)
  );

  // On divide-by-zero the remainder is the original dividend, recovered from |dividend|.
  assign rem_src = core_div0 ? core_a : core_r;

  // Quotient negative when signs differ; remainder takes the dividend's sign.
  div_sign_fix #(.W(DATA_W)) u_post_fix (
    .a     (core_q),
    .neg_a (sa ^ sb),
    .b     (rem_src),
    .neg_b (sa),
    .a_fix (q_fix),
    .b_fix (r_fix)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic              c_vld;
  logic              c_sgn;
  logic [DATA_W-1:0] c_a;
  logic [DATA_W-1:0] c_b;
  logic [DATA_W-1:0] c_hi;
  logic [DATA_W-1:0] c_lo;
  logic              c_div0;
  logic              op_sgn_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  assign cache_hit  = c_vld & (c_sgn == op_signed) & (c_a == op_a) & (c_b == op_b);
  assign cache_hi   = c_hi;
  assign cache_lo   = c_lo;
  assign cache_div0 = c_div0;

  // Remember the raw operands of the op in flight and the last completed op's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld    <= 1'b0;
      c_sgn    <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_hi     <= '0;
      c_lo     <= '0;
      c_div0   <= 1'b0;
      op_sgn_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      if (state == IDLE && issue && !cache_hit) begin
        op_sgn_q <= op_signed;
        op_a_q   <= op_a;
        op_b_q   <= op_b;
      end
      if (state == WAIT && core_done && !flush) begin
        c_vld  <= 1'b1;
        c_sgn  <= op_sgn_q;
        c_a    <= op_a_q;
        c_b    <= op_b_q;
        c_hi   <= r_fix;
        c_lo   <= core_div0 ? DIV0_QUOTIENT : q_fix;
        c_div0 <= core_div0;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_hi   = '0;
  assign cache_lo   = '0;
  assign cache_div0 = 1'b0;
`endif

  // Hold EX while an op is issuing or in the core; a flush releases it immediately.
  // In DRAIN a newly presented op is held until the stale core result has been discarded.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE, DRAIN: stall = op_valid & ~flush;
      START, WAIT: stall = ~flush;
      default:     stall = 1'b0;
    endcase
  end

  // Sequencer: issue, start pulse, wait for core, sign-fix result; drain flushed ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= 1'b0;
      sb        <= 1'b0;
      core_en   <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
      res_valid <= 1'b0;
      div0      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      core_en   <= 1'b0;
      res_valid <= 1'b0;
      div0      <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            if (cache_hit) begin
              res_valid <= 1'b1;
              hi        <= cache_hi;
              lo        <= cache_lo;
              div0      <= cache_div0;
            end else begin
              sa      <= in_sa;
              sb      <= in_sb;
              core_a  <= in_a_mag;
              core_b  <= in_b_mag;
              core_en <= 1'b1;
              state   <= START;
            end
          end
        end
        START: begin
          // The start pulse is already on the wire; a flush here only redirects to DRAIN.
          state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= core_done ? IDLE : DRAIN;
          end else if (core_done) begin
            hi        <= r_fix;
            lo        <= core_div0 ? DIV0_QUOTIENT : q_fix;
            div0      <= core_div0;
            res_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (core_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
